// File: rtl/alu_branch_unit_pkg.sv
// alu_branch_unit_pkg: shared types and encodings for the execute-stage ALU/branch unit
package alu_branch_unit_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] data_t;
  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_XOR    = 4'b0011,
    ALU_SLL    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_SUB    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;
  typedef enum logic [2:0] {
    AOP_MEM    = 3'b000,
    AOP_BRANCH = 3'b001,
    AOP_RTYPE  = 3'b010,
    AOP_ITYPE  = 3'b011,
    AOP_LUI    = 3'b100,
    AOP_AUIPC  = 3'b101,
    AOP_JALR   = 3'b110,
    AOP_RSVD   = 3'b111
  } aluop_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/alu_branch_unit_if.sv
// alu_branch_unit_if: control/operand inputs and result/branch outputs of the execute stage
interface alu_branch_unit_if;
  import alu_branch_unit_pkg::*;
  logic [2:0] i_ALUOp;
  logic [2:0] i_Funct3;
  logic [6:0] i_Funct7;
  data_t      i_Op1;
  data_t      i_Op2;
  logic       i_Branch;
  logic       i_Jump;
  data_t      o_Result;
  logic       o_Zero;
  logic [3:0] o_ALUControlLines;
  logic       o_B_J_result;
  logic [31:0] o_TakenCount;
  modport master (
    output i_ALUOp, i_Funct3, i_Funct7, i_Op1, i_Op2, i_Branch, i_Jump,
    input  o_Result, o_Zero, o_ALUControlLines, o_B_J_result, o_TakenCount
  );
  modport slave (
    input  i_ALUOp, i_Funct3, i_Funct7, i_Op1, i_Op2, i_Branch, i_Jump,
    output o_Result, o_Zero, o_ALUControlLines, o_B_J_result, o_TakenCount
  );
endinterface

// File: rtl/alu_branch_unit_alu_core.sv
// alu_core: combinational 32-bit ALU operations and zero flag
module alu_core
  import alu_branch_unit_pkg::*;
(
  input  alu_op_e op,
  input  data_t   a,
  input  data_t   b,
  output data_t   result,
  output logic    zero
);
  logic [4:0] shamt;
  assign shamt = b[4:0];
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_ADD:    result = a + b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SUB:    result = a - b;
      ALU_SRA:    result = data_t'($signed(a) >>> shamt);
      ALU_SLT:    result = data_t'($signed(a) < $signed(b));
      ALU_SLTU:   result = data_t'(a < b);
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end
  assign zero = (result == '0);
endmodule

// File: rtl/alu_branch_unit.sv
// alu_branch_unit: ALU control decode, branch/jump resolve and taken counter
module alu_branch_unit
  import alu_branch_unit_pkg::*;
(
  input logic i_clk,
  input logic i_rstn,
  alu_branch_unit_if.slave bus
);
  alu_op_e    ctrl;
  logic [2:0] f3;
  logic       alt;
  logic       is_r;
  logic       sig;
  logic       cond;
  logic       taken;
  logic [31:0] taken_count;
  assign f3   = bus.i_Funct3;
  assign alt  = bus.i_Funct7[5];
  assign is_r = (aluop_e'(bus.i_ALUOp) == AOP_RTYPE);
  always_comb begin
    ctrl = ALU_ADD;
    case (aluop_e'(bus.i_ALUOp))
      AOP_BRANCH: ctrl = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : (f3[1] ? ALU_ADD : ALU_SUB);
      AOP_RTYPE, AOP_ITYPE:
        case (f3)
          3'b000:  ctrl = (is_r && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      AOP_LUI: ctrl = ALU_PASS_B;
      default: ctrl = ALU_ADD;
    endcase
  end
  alu_core u_alu (
    .op    (ctrl),
    .a     (bus.i_Op1),
    .b     (bus.i_Op2),
    .result(bus.o_Result),
    .zero  (bus.o_Zero)
  );
  // f3[0] inverts the sense in both the zero-based and the compare-based branch pairs
  assign sig   = bus.o_Result[0];
  assign cond  = f3[2] ? (sig ^ f3[0]) : (f3[1] ? 1'b0 : (bus.o_Zero ^ f3[0]));
  assign taken = bus.i_Jump | (bus.i_Branch & cond);
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) taken_count <= '0;
    else if (taken) taken_count <= taken_count + 32'd1;
  assign bus.o_ALUControlLines = ctrl;
  assign bus.o_B_J_result      = taken;
  assign bus.o_TakenCount      = taken_count;
endmodule

// File: tb/tb_alu_branch_unit.sv
// tb_alu_branch_unit: directed checks of decode, ALU, branch resolve and taken counter
module tb_alu_branch_unit;
  logic clk = 1'b0;
  logic rstn;
  int   passed = 0;
  int   total = 0;
  alu_branch_unit_if bus ();
  alu_branch_unit dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic drive(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic br, input logic j);
    bus.i_ALUOp = aop; bus.i_Funct3 = f3; bus.i_Funct7 = f7;
    bus.i_Op1 = a; bus.i_Op2 = b; bus.i_Branch = br; bus.i_Jump = j;
    #1;
  endtask
  initial begin
    rstn = 1'b0;
    drive(3'b000, 3'b000, 7'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    check("reset_count", bus.o_TakenCount, 32'd0);
    drive(3'b010, 3'b000, 7'h20, 32'd5, 32'd7, 1'b0, 1'b0);
    check("sub_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd6);
    check("sub_res", bus.o_Result, 32'hFFFFFFFE);
    check("sub_zero", {31'd0, bus.o_Zero}, 32'd0);
    drive(3'b010, 3'b101, 7'h20, 32'h80000000, 32'd4, 1'b0, 1'b0);
    check("sra_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd7);
    check("sra_res", bus.o_Result, 32'hF8000000);
    drive(3'b010, 3'b101, 7'h00, 32'h80000000, 32'd4, 1'b0, 1'b0);
    check("srl_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd5);
    check("srl_res", bus.o_Result, 32'h08000000);
    drive(3'b001, 3'b000, 7'h00, 32'd9, 32'd9, 1'b1, 1'b0);
    check("beq_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd6);
    check("beq_zero", {31'd0, bus.o_Zero}, 32'd1);
    check("beq_taken", {31'd0, bus.o_B_J_result}, 32'd1);
    drive(3'b001, 3'b001, 7'h00, 32'd9, 32'd9, 1'b1, 1'b0);
    check("bne_taken", {31'd0, bus.o_B_J_result}, 32'd0);
    drive(3'b001, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    check("blt_res", bus.o_Result, 32'd1);
    check("blt_taken", {31'd0, bus.o_B_J_result}, 32'd1);
    drive(3'b001, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    check("bge_taken", {31'd0, bus.o_B_J_result}, 32'd0);
    drive(3'b001, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    check("bltu_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd9);
    check("bltu_res", bus.o_Result, 32'd0);
    check("bltu_taken", {31'd0, bus.o_B_J_result}, 32'd0);
    drive(3'b001, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    check("bgeu_taken", {31'd0, bus.o_B_J_result}, 32'd1);
    drive(3'b001, 3'b010, 7'h00, 32'd9, 32'd9, 1'b1, 1'b0);
    check("br010_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd2);
    check("br010_taken", {31'd0, bus.o_B_J_result}, 32'd0);
    drive(3'b001, 3'b000, 7'h00, 32'd9, 32'd8, 1'b0, 1'b0);
    check("nobranch_taken", {31'd0, bus.o_B_J_result}, 32'd0);
    drive(3'b110, 3'b000, 7'h00, 32'h100, 32'd8, 1'b0, 1'b1);
    check("jalr_res", bus.o_Result, 32'h108);
    check("jalr_taken", {31'd0, bus.o_B_J_result}, 32'd1);
    drive(3'b001, 3'b010, 7'h00, 32'd1, 32'd2, 1'b1, 1'b1);
    check("jump_wins", {31'd0, bus.o_B_J_result}, 32'd1);
    drive(3'b011, 3'b000, 7'h20, 32'd3, 32'd4, 1'b0, 1'b0);
    check("addi_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd2);
    check("addi_res", bus.o_Result, 32'd7);
    drive(3'b011, 3'b101, 7'h20, 32'h80000000, 32'd4, 1'b0, 1'b0);
    check("srai_res", bus.o_Result, 32'hF8000000);
    drive(3'b100, 3'b000, 7'h00, 32'hDEAD, 32'h12345000, 1'b0, 1'b0);
    check("lui_ctrl", {28'd0, bus.o_ALUControlLines}, 32'd10);
    check("lui_res", bus.o_Result, 32'h12345000);
    drive(3'b010, 3'b111, 7'h00, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
    check("and_res", bus.o_Result, 32'h0000F000);
    drive(3'b010, 3'b110, 7'h00, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
    check("or_res", bus.o_Result, 32'h0000FFF0);
    drive(3'b010, 3'b100, 7'h00, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0);
    check("xor_res", bus.o_Result, 32'h00000FF0);
    drive(3'b010, 3'b001, 7'h00, 32'd1, 32'h21, 1'b0, 1'b0);
    check("sll_res", bus.o_Result, 32'd2);
    drive(3'b010, 3'b010, 7'h00, 32'h80000000, 32'd1, 1'b0, 1'b0);
    check("slt_res", bus.o_Result, 32'd1);
    drive(3'b010, 3'b011, 7'h00, 32'h80000000, 32'd1, 1'b0, 1'b0);
    check("sltu_res", bus.o_Result, 32'd0);
    drive(3'b000, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    check("wrap_res", bus.o_Result, 32'd0);
    check("wrap_zero", {31'd0, bus.o_Zero}, 32'd1);
    drive(3'b111, 3'b000, 7'h20, 32'd10, 32'd3, 1'b0, 1'b0);
    check("rsvd_res", bus.o_Result, 32'd13);
    @(posedge clk);
    check("count_held_in_reset", bus.o_TakenCount, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive(3'b000, 3'b000, 7'h00, 32'd0, 32'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.i_Jump = 1'b0;
    #1 check("count3", bus.o_TakenCount, 32'd3);
    @(negedge clk);
    #1 check("count_hold", bus.o_TakenCount, 32'd3);
    bus.i_Jump = 1'b1;
    @(negedge clk);
    #1 check("count4", bus.o_TakenCount, 32'd4);
    #1 rstn = 1'b0;
    #1 check("async_clear", bus.o_TakenCount, 32'd0);
    bus.i_Jump = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    force dut.taken_count = 32'hFFFFFFFF;
    #1 release dut.taken_count;
    #1 check("preload", bus.o_TakenCount, 32'hFFFFFFFF);
    bus.i_Jump = 1'b1;
    @(negedge clk);
    bus.i_Jump = 1'b0;
    #1 check("count_wrap", bus.o_TakenCount, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
